// File: rtl/reg_sel_pkg.sv
// Shared defaults and field-select type for the register select / scoreboard block.
// Optional build macro used by the block: R0_HARDWIRE_EN (R0 reads as constant zero).
package reg_sel_pkg;

    localparam int NUM_REGS_DEF = 16;
    localparam int IR_W_DEF     = 32;
    localparam int RA_LSB_DEF   = 23;
    localparam int RB_LSB_DEF   = 19;
    localparam int RC_LSB_DEF   = 15;
    localparam int IMM_W_DEF    = 19;

    typedef enum logic [1:0] {
        FLD_NONE = 2'd0,
        FLD_A    = 2'd1,
        FLD_B    = 2'd2,
        FLD_C    = 2'd3
    } fld_sel_e;

    // Ra wins over Rb, which wins over Rc.
    function automatic fld_sel_e pick_field(input logic gra, input logic grb, input logic grc);
        if (gra)      return FLD_A;
        else if (grb) return FLD_B;
        else if (grc) return FLD_C;
        else          return FLD_NONE;
    endfunction

endpackage

// File: rtl/reg_select_scoreboard_if.sv
// Control-unit facing bus of reg_select_scoreboard: strobes and IR in, enables, immediate
// and hazard status out. master = control unit side, slave = the select block.
interface reg_select_scoreboard_if
    import reg_sel_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int IR_W     = IR_W_DEF
);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic                ir_ld;
    logic [IR_W-1:0]     ir_in;
    logic                gra;
    logic                grb;
    logic                grc;
    logic                rin;
    logic                rout;
    logic                baout;
    logic                pend_set;
    logic                pend_clr;
    logic [SEL_W-1:0]    pend_clr_idx;
    logic [NUM_REGS-1:0] rin_out;
    logic [NUM_REGS-1:0] rout_out;
    logic [IR_W-1:0]     c_sign_ext;
    logic                zero_base;
    logic                stall;
    logic [NUM_REGS-1:0] pend_mask;

    modport master (
        output ir_ld, ir_in, gra, grb, grc, rin, rout, baout,
               pend_set, pend_clr, pend_clr_idx,
        input  rin_out, rout_out, c_sign_ext, zero_base, stall, pend_mask
    );

    modport slave (
        input  ir_ld, ir_in, gra, grb, grc, rin, rout, baout,
               pend_set, pend_clr, pend_clr_idx,
        output rin_out, rout_out, c_sign_ext, zero_base, stall, pend_mask
    );

endinterface

// File: rtl/reg_select_scoreboard_onehot_decoder.sv
// Binary index to one-hot enable decoder; all-zero output when en is low.
module onehot_decoder
    import reg_sel_pkg::*;
#(
    parameter int N     = NUM_REGS_DEF,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [SEL_W-1:0] idx,
    input  logic             en,
    output logic [N-1:0]     onehot
);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign onehot[gi] = en && (idx == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/reg_select_scoreboard.sv
// Registered register-field select/encode with a pending-write scoreboard and read-hazard stall.
// Build macro R0_HARDWIRE_EN: R0 is constant zero (no writes, no pending, reads act as BAout).
module reg_select_scoreboard
    import reg_sel_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int IR_W     = IR_W_DEF,
    parameter int RA_LSB   = RA_LSB_DEF,
    parameter int RB_LSB   = RB_LSB_DEF,
    parameter int RC_LSB   = RC_LSB_DEF,
    parameter int IMM_W    = IMM_W_DEF
) (
    input  logic                   clk,
    input  logic                   clr_n,
    reg_select_scoreboard_if.slave bus
);

    localparam int SEL_W = $clog2(NUM_REGS);

    logic [IR_W-1:0]     ir_q, ir_d;
    logic [NUM_REGS-1:0] rin_out_q, rin_out_d;
    logic [NUM_REGS-1:0] rout_out_q, rout_out_d;
    logic [IR_W-1:0]     c_sign_ext_q, c_sign_ext_d;
    logic                zero_base_q, zero_base_d;
    logic [NUM_REGS-1:0] pend_q, pend_d;

    fld_sel_e            fld;
    logic [SEL_W-1:0]    idx;
    logic [SEL_W-1:0]    ra_idx;
    logic                sel_valid;
    logic                read_req;
    logic                r0_zero;
    logic                wr_en;
    logic                rd_en;
    logic                stall_c;
    logic                pend_set_ok;

    // Field extraction always works on the latched IR, so an ir_ld in this cycle is not seen yet.
    always_comb begin
        fld    = pick_field(bus.gra, bus.grb, bus.grc);
        ra_idx = ir_q[RA_LSB +: SEL_W];
        idx    = '0;
        case (fld)
            FLD_A:   idx = ir_q[RA_LSB +: SEL_W];
            FLD_B:   idx = ir_q[RB_LSB +: SEL_W];
            FLD_C:   idx = ir_q[RC_LSB +: SEL_W];
            default: idx = '0;
        endcase
        sel_valid = (fld != FLD_NONE);
        read_req  = bus.rout | bus.baout;
`ifdef R0_HARDWIRE_EN
        r0_zero     = sel_valid & (idx == '0) & read_req;
        wr_en       = bus.rin & sel_valid & (idx != '0);
        pend_set_ok = bus.pend_set & (ra_idx != '0);
`else
        r0_zero     = sel_valid & (idx == '0) & bus.baout;
        wr_en       = bus.rin & sel_valid;
        pend_set_ok = bus.pend_set;
`endif
        stall_c = read_req & sel_valid & pend_q[idx] & ~r0_zero;
        rd_en   = read_req & sel_valid & ~stall_c & ~r0_zero;
    end

    onehot_decoder #(.N(NUM_REGS), .SEL_W(SEL_W)) u_wr_dec (
        .idx    (idx),
        .en     (wr_en),
        .onehot (rin_out_d)
    );

    onehot_decoder #(.N(NUM_REGS), .SEL_W(SEL_W)) u_rd_dec (
        .idx    (idx),
        .en     (rd_en),
        .onehot (rout_out_d)
    );

    // Clear is applied first so a same-index set overrides it.
    always_comb begin
        ir_d         = bus.ir_ld ? bus.ir_in : ir_q;
        zero_base_d  = r0_zero;
        c_sign_ext_d = {{(IR_W - IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
        pend_d       = pend_q;
        if (bus.pend_clr) begin
            pend_d[bus.pend_clr_idx] = 1'b0;
        end
        if (pend_set_ok) begin
            pend_d[ra_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ir_q         <= '0;
            rin_out_q    <= '0;
            rout_out_q   <= '0;
            c_sign_ext_q <= '0;
            zero_base_q  <= 1'b0;
            pend_q       <= '0;
        end else begin
            ir_q         <= ir_d;
            rin_out_q    <= rin_out_d;
            rout_out_q   <= rout_out_d;
            c_sign_ext_q <= c_sign_ext_d;
            zero_base_q  <= zero_base_d;
            pend_q       <= pend_d;
        end
    end

    assign bus.rin_out    = rin_out_q;
    assign bus.rout_out   = rout_out_q;
    assign bus.c_sign_ext = c_sign_ext_q;
    assign bus.zero_base  = zero_base_q;
    assign bus.stall      = stall_c;
    assign bus.pend_mask  = pend_q;

endmodule

// File: tb/tb_reg_select_scoreboard.sv
// Randomized scoreboard bench for reg_select_scoreboard against a field-level reference model.
module tb_reg_select_scoreboard;

`ifdef R0_HARDWIRE_EN
    localparam bit HW = 1'b1;
`else
    localparam bit HW = 1'b0;
`endif

    logic clk;
    logic clr_n;

    reg_select_scoreboard_if #(.NUM_REGS(16), .IR_W(32)) bus ();

    reg_select_scoreboard #(
        .NUM_REGS (16),
        .IR_W     (32),
        .RA_LSB   (23),
        .RB_LSB   (19),
        .RC_LSB   (15),
        .IMM_W    (19)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rin;
        logic [15:0] rout;
        logic [31:0] csx;
        logic        zb;
        logic [15:0] pend;
    } exp_t;

    exp_t      exp_q[$];
    int        errors = 0;
    int        checks = 0;
    int        txn    = 0;
    bit [31:0] m_ir;
    bit        m_pend[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic set_idle();
        bus.ir_ld = 0; bus.ir_in = 0; bus.gra = 0; bus.grb = 0; bus.grc = 0;
        bus.rin = 0; bus.rout = 0; bus.baout = 0;
        bus.pend_set = 0; bus.pend_clr = 0; bus.pend_clr_idx = 0;
    endtask

    // One cycle of stimulus; expected registered outputs go to the queue for the monitor.
    task automatic drive(input bit ld, input bit [31:0] irin,
                         input bit a, input bit b, input bit c,
                         input bit wr, input bit rd, input bit ba,
                         input bit ps, input bit pc, input bit [3:0] pci);
        int   idx;
        int   ra;
        int   imm;
        bit   has;
        bit   zero;
        bit   stl;
        exp_t e;
        @(negedge clk);
        bus.ir_ld = ld; bus.ir_in = irin; bus.gra = a; bus.grb = b; bus.grc = c;
        bus.rin = wr; bus.rout = rd; bus.baout = ba;
        bus.pend_set = ps; bus.pend_clr = pc; bus.pend_clr_idx = pci;
        ra  = int'((m_ir >> 23) % 16);
        has = 1;
        idx = 0;
        if (a)      idx = ra;
        else if (b) idx = int'((m_ir >> 19) % 16);
        else if (c) idx = int'((m_ir >> 15) % 16);
        else        has = 0;
        zero = has && idx == 0 && (ba || (HW && rd));
        stl  = (rd || ba) && has && m_pend[idx] && !zero;
        #1;
        chk("stall", {31'd0, bus.stall}, {31'd0, stl});
        e.rin  = (wr && has && !(HW && idx == 0)) ? 16'(1 << idx) : 16'd0;
        e.rout = ((rd || ba) && has && !stl && !zero) ? 16'(1 << idx) : 16'd0;
        e.zb   = zero;
        imm    = int'(m_ir % (1 << 19));
        e.csx  = (imm >= (1 << 18)) ? 32'(imm - (1 << 19)) : 32'(imm);
        if (pc) m_pend[pci] = 0;
        if (ps && !(HW && ra == 0)) m_pend[ra] = 1;
        for (int i = 0; i < 16; i++) e.pend[i] = m_pend[i];
        if (ld) m_ir = irin;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                chk("rin_out",    {16'd0, bus.rin_out},  {16'd0, e.rin});
                chk("rout_out",   {16'd0, bus.rout_out}, {16'd0, e.rout});
                chk("c_sign_ext", bus.c_sign_ext,        e.csx);
                chk("zero_base",  {31'd0, bus.zero_base}, {31'd0, e.zb});
                chk("pend_mask",  {16'd0, bus.pend_mask}, {16'd0, e.pend});
                $display("txn %0d: rin=%h rout=%h csx=%h zb=%0d pend=%h",
                         txn, bus.rin_out, bus.rout_out, bus.c_sign_ext, bus.zero_base, bus.pend_mask);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_rin_out"},    {16'd0, bus.rin_out},   32'd0);
        chk({tag, "_rout_out"},   {16'd0, bus.rout_out},  32'd0);
        chk({tag, "_c_sign_ext"}, bus.c_sign_ext,         32'd0);
        chk({tag, "_zero_base"},  {31'd0, bus.zero_base}, 32'd0);
        chk({tag, "_pend_mask"},  {16'd0, bus.pend_mask}, 32'd0);
    endtask

    initial begin : stim
        int wait_cycles;
        set_idle();
        m_ir = 0;
        for (int i = 0; i < 16; i++) m_pend[i] = 0;
        clr_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        #1;
        check_all_zero("por");

        // Decode: Ra=5, Rb=9
        drive(1, (32'd5 << 23) | (32'd9 << 19), 0,0,0, 0,0,0, 0,0,0);
        drive(0, 0, 1,0,0, 1,0,0, 0,0,0);
        drive(0, 0, 0,1,0, 0,1,0, 0,0,0);
        // Priority: Ra=3, Rc=12 with gra+grc
        drive(1, (32'd3 << 23) | (32'd12 << 15), 0,0,0, 0,0,0, 0,0,0);
        drive(0, 0, 1,0,1, 0,1,0, 0,0,0);
        // Negative immediate
        drive(1, 32'h0004_0001, 0,0,0, 0,0,0, 0,0,0);
        drive(0, 0, 0,0,0, 0,0,0, 0,0,0);
        drive(0, 0, 0,0,0, 0,0,0, 0,0,0);
        // BAout on R0, then on R7
        drive(1, 32'd0, 0,0,0, 0,0,0, 0,0,0);
        drive(0, 0, 0,1,0, 0,1,1, 0,0,0);
        drive(1, 32'd7 << 19, 0,0,0, 0,0,0, 0,0,0);
        drive(0, 0, 0,1,0, 0,0,1, 0,0,0);
        // Scoreboard on R4: set, stalled read, clear, read, set+clear together
        drive(1, (32'd4 << 23) | (32'd4 << 19), 0,0,0, 0,0,0, 0,0,0);
        drive(0, 0, 0,0,0, 0,0,0, 1,0,0);
        drive(0, 0, 0,1,0, 0,1,0, 0,0,0);
        drive(0, 0, 0,0,0, 0,0,0, 0,1,4);
        drive(0, 0, 0,1,0, 0,1,0, 0,0,0);
        drive(0, 0, 0,0,0, 0,0,0, 1,1,4);
        drive(0, 0, 0,1,0, 0,1,0, 0,0,0);
        // R0 write and read
        drive(1, 32'd0, 0,0,0, 0,0,0, 0,0,0);
        drive(0, 0, 1,0,0, 1,0,0, 0,0,0);
        drive(0, 0, 1,0,0, 0,1,0, 0,0,0);

        // Mark every register pending, then reset asynchronously mid-cycle
        for (int i = 0; i <= 16; i++)
            drive(1, 32'(i % 16) << 23, 0,0,0, 0,0,0, 1,0,0);
        drive(0, 0, 1,0,0, 1,1,0, 0,0,0);
        @(posedge clk);
        #3;
        set_idle();
        clr_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        chk("async_rst_stall", {31'd0, bus.stall}, 32'd0);
        m_ir = 0;
        for (int i = 0; i < 16; i++) m_pend[i] = 0;
        @(negedge clk);
        clr_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            drive(($urandom % 4) == 0, $urandom,
                  $urandom % 2, $urandom % 2, $urandom % 2,
                  $urandom % 2, $urandom % 2, ($urandom % 4) == 0,
                  ($urandom % 3) == 0, ($urandom % 3) == 0, 4'($urandom % 16));
        end
        @(negedge clk);
        set_idle();

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_select_scoreboard.md
Name: reg_select_scoreboard

Overview:
- Parametrised, registered successor to the datapath's register select/encode logic.
- Latches the instruction word and selects a register field (Ra/Rb/Rc) from the control unit's strobes.
- Drives one-hot register-file in/out enables, a sign-extended C immediate, and a base-zero flag for BAout on R0.
- Tracks pending write-backs in a scoreboard and raises stall when a read targets a pending register. Sits between the control unit and the register file.

Parameters:
NUM_REGS, 16, number of general registers; power of two, 2..64
IR_W, 32, instruction register width
RA_LSB, 23, LSB of Ra field
RB_LSB, 19, LSB of Rb field
RC_LSB, 15, LSB of Rc field
IMM_W, 19, C immediate width; bit IMM_W-1 is the sign bit
(localparam SEL_W = $clog2(NUM_REGS); every field is SEL_W bits wide)

Ports:
clk  in  1  rising-edge clock
clr_n  in  1  asynchronous active-low reset
ir_ld  in  1  load ir_in into internal IR
ir_in  in  IR_W  instruction word
gra, grb, grc  in  1 each  field select strobes
rin  in  1  request register write enable
rout  in  1  request register read enable
baout  in  1  base-address read (R0 reads as zero)
pend_set  in  1  mark Ra of the latched IR as pending write
pend_clr  in  1  clear one pending bit
pend_clr_idx  in  SEL_W  index to clear
rin_out  out  NUM_REGS  one-hot write enable, registered
rout_out  out  NUM_REGS  one-hot read enable, registered
c_sign_ext  out  IR_W  sign-extended C field of the latched IR, registered
zero_base  out  1  BAout selected R0, registered
stall  out  1  combinational read hazard
pend_mask  out  NUM_REGS  scoreboard state

Behaviour:
- Reset (clr_n=0, asynchronous): IR, rin_out, rout_out, c_sign_ext, zero_base and pend_mask all go to 0.
- IR: ir_q <= ir_in on ir_ld.
- Decode in the same cycle as ir_ld uses the old ir_q. New fields take effect the following cycle.
- Field select priority: gra > grb > grc. If none is asserted there is no selection and both one-hot outputs go to 0 next cycle. No latch of the previous index.
- Latency: strobes at edge N produce outputs valid after edge N+1. Outputs are re-evaluated every cycle, not held.
- rin_out: one-hot of idx when rin=1 and a field is selected, else 0.
- Read path, baout=1 and idx=0: rout_out=0 and zero_base=1. This holds regardless of rout.
- Read path, otherwise: if (rout or baout), a field is selected and no stall, then rout_out=one-hot(idx) and zero_base=0. Else rout_out=0 and zero_base=0.
- stall = (rout or baout) and a field is selected and pend_mask[idx] and not (baout and idx=0).
  - While stall=1, rout_out is forced to 0 next cycle.
  - rin is unaffected by stall.
- c_sign_ext = sign-extend ir_q[IMM_W-1:0] to IR_W. Registered every cycle.
- Scoreboard:
  - pend_set sets bit ir_q[RA_LSB+:SEL_W].
  - pend_clr clears bit pend_clr_idx.
  - Same index set and cleared in one cycle: set wins. Different indices: both apply.
- pend_set on an already-pending bit: no change, no error.
- Reset mid-operation: the scoreboard is lost and the control unit must re-issue.

Optional Feature:
R0_HARDWIRE_EN
- Defined: R0 is constant zero.
  - rin_out[0] is never asserted.
  - pend_set targeting R0 is ignored.
  - rout with idx=0 behaves like baout (zero_base=1, rout_out=0).
- Undefined: R0 is an ordinary register, as described above.

Decomposition:
- Package reg_sel_pkg: default NUM_REGS, IR_W, RA_LSB/RB_LSB/RC_LSB, IMM_W, and a field-select enum FLD_NONE/FLD_A/FLD_B/FLD_C.
- Sub-module onehot_decoder (parameter N, in SEL_W-bit idx plus enable, out N-bit one-hot). Instantiated twice, for the write and read paths.

Test Plan:
- Reset: hold clr_n=0 mid-cycle with pend_mask=16'hFFFF -> all outputs 0 immediately, no clock edge needed.
- Decode: ir_ld with Ra=5 and Rb=9, next cycle gra+rin -> rin_out=16'h0020 after one edge; grb+rout -> rout_out=16'h0200.
- Priority and immediate: gra+grc with Ra=3, Rc=12, rout -> rout_out=16'h0008. IR[18:0]=19'h40001 -> c_sign_ext=32'hFFFC0001.
- BAout: Rb=0, grb+baout+rout -> rout_out=0, zero_base=1. Rb=7, grb+baout -> rout_out=16'h0080.
- Scoreboard: pend_set with Ra=4, then grb read of R4 -> stall=1, rout_out=0. Then pend_clr with idx 4 -> stall=0 and rout_out=16'h0010 next edge. Simultaneous set and clear of 4 -> bit stays 1.
- R0_HARDWIRE_EN: rin on R0 -> rin_out=0. rout on R0 -> zero_base=1.
